stopwatch_mode_controller: RTL and testbench

Parametrised successor to the single-mode stopwatch controller. It merges the run/pause/clear/alarm state machine with its own time-base counter, and adds:
- a count-down mode with loadable preset
- lap capture (configurable, see Configuration)
- an alarm that ends itself after a set time.

It sits between the key debouncers and the display/beeper logic, and consumes the system tick pulse.

---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/stopwatch_count_core.sv | 53 +++++
 rtl/stopwatch_mode_controller.sv | 183 ++++++++++++++++++
 tb/tb_stopwatch_mode_controller.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch mode controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_ALARM   = 2'b11
    } state_t;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

endpackage

// File: rtl/stopwatch_count_core.sv
// Up/down tick counter with load and terminal detection (MAX_COUNT up, 0 down).
// Latency: count updates one cycle after load/en; terminal_hit is combinational on en.
// Backpressure: none; load has priority over en.
module stopwatch_count_core
    import stopwatch_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int MAX_COUNT = 5999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    output logic [CNT_W-1:0] count,
    output logic             terminal_hit
);

    localparam logic [CNT_W-1:0] TERM_UP = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] step_val;
    logic [CNT_W-1:0] term_val;

    // Next count and terminal detection; terminal is judged on the stepped value
    // so the owning FSM can leave RUNNING on the same edge, which also prevents wrap.
    always_comb begin
        step_val     = (dir == MODE_DOWN) ? (count_q - ONE) : (count_q + ONE);
        term_val     = (dir == MODE_DOWN) ? '0 : TERM_UP;
        terminal_hit = en && (step_val == term_val);
        count_d      = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = step_val;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/stopwatch_mode_controller.sv
// Stopwatch run/pause/clear/alarm FSM with up/down count, self-ending alarm, optional lap (LAP_CAPTURE_EN).
// Latency: one cycle from key/tick pulse to registered output change; decoded outputs come from state flops.
// Backpressure: none; keys resolved by priority C > B > A > D, only the highest legal key acts.
module stopwatch_mode_controller
    import stopwatch_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MAX_COUNT   = 5999,
    parameter int ALARM_TICKS = 300
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_pulse,
    input  logic             key_a_pulse,
    input  logic             key_b_pulse,
    input  logic             key_c_pulse,
    input  logic             key_d_pulse,
    input  logic             mode_down,
    input  logic [CNT_W-1:0] preset_in,
    output logic [CNT_W-1:0] count_out,
    output logic [CNT_W-1:0] lap_out,
    output logic             lap_hold_out,
    output logic             run_en_out,
    output logic             alarm_active_out,
    output logic             mode_down_out,
    output logic [1:0]       state_out
);

    // One spare bit so the timer can always reach ALARM_TICKS without wrapping first.
    localparam int AT_W = $clog2(ALARM_TICKS + 1) + 1;
    localparam logic [AT_W-1:0] ALARM_LIM = AT_W'(ALARM_TICKS);
    localparam logic [AT_W-1:0] AT_ONE    = AT_W'(1);

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [AT_W-1:0]  timer_q, timer_d, timer_inc;
    logic             core_load;
    logic [CNT_W-1:0] core_load_val;
    logic [CNT_W-1:0] count;
    logic             tick_run;
    logic             terminal_hit;
    logic             alarm_done;
    logic             d_act;

    assign tick_run   = (state_q == ST_RUNNING) && tick_pulse;
    assign timer_inc  = timer_q + AT_ONE;
    // ALARM_TICKS of zero disables the timeout entirely.
    assign alarm_done = (ALARM_TICKS != 0) && tick_pulse && (timer_inc == ALARM_LIM);

    stopwatch_count_core #(
        .CNT_W     (CNT_W),
        .MAX_COUNT (MAX_COUNT)
    ) u_core (
        .clk          (clk),
        .reset        (reset),
        .load         (core_load),
        .load_val     (core_load_val),
        .en           (tick_run),
        .dir          (mode_q),
        .count        (count),
        .terminal_hit (terminal_hit)
    );

    // Next state, counter load, mode latch, alarm timer and lap-key qualification.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        timer_d       = '0;
        core_load     = 1'b0;
        core_load_val = '0;
        d_act         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mode_d = mode_down;
                // A zero preset in down mode would alarm instantly, so A is ignored.
                if (key_a_pulse && ((mode_down == MODE_UP) || (preset_in != '0))) begin
                    state_d       = ST_RUNNING;
                    core_load     = 1'b1;
                    core_load_val = (mode_down == MODE_DOWN) ? preset_in : '0;
                end
            end
            ST_RUNNING: begin
                if (key_c_pulse) begin
                    state_d = ST_IDLE;
                end else begin
                    // Terminal beats pause; the tick is applied either way.
                    if (terminal_hit) begin
                        state_d = ST_ALARM;
                    end else if (key_b_pulse) begin
                        state_d = ST_PAUSED;
                    end
                    d_act = key_d_pulse && !key_b_pulse;
                end
            end
            ST_PAUSED: begin
                if (key_c_pulse) begin
                    state_d = ST_IDLE;
                end else if (key_a_pulse) begin
                    state_d = ST_RUNNING;
                end else begin
                    d_act = key_d_pulse;
                end
            end
            ST_ALARM: begin
                timer_d = tick_pulse ? timer_inc : timer_q;
                if (key_c_pulse || alarm_done) begin
                    state_d = ST_IDLE;
                end else begin
                    d_act = key_d_pulse;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Every path into (or staying in) IDLE zeroes the count on the same edge.
        if (state_d == ST_IDLE) begin
            core_load     = 1'b1;
            core_load_val = '0;
        end
    end

    // FSM, mode latch and alarm timer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_UP;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            timer_q <= timer_d;
        end
    end

`ifdef LAP_CAPTURE_EN
    logic [CNT_W-1:0] lap_q, lap_d;
    logic             hold_q, hold_d;

    // Lap capture takes the pre-tick count; D while holding releases in any state.
    always_comb begin
        lap_d  = lap_q;
        hold_d = hold_q;
        if (state_d == ST_IDLE) begin
            lap_d  = '0;
            hold_d = 1'b0;
        end else if (d_act) begin
            if (hold_q) begin
                hold_d = 1'b0;
            end else if (state_q == ST_RUNNING) begin
                lap_d  = count;
                hold_d = 1'b1;
            end
        end
    end

    // Lap registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_q  <= '0;
            hold_q <= 1'b0;
        end else begin
            lap_q  <= lap_d;
            hold_q <= hold_d;
        end
    end

    assign lap_out      = lap_q;
    assign lap_hold_out = hold_q;
`else
    logic lap_unused;
    assign lap_unused   = key_d_pulse ^ d_act;
    assign lap_out      = '0;
    assign lap_hold_out = 1'b0;
`endif

    assign count_out        = count;
    assign run_en_out       = (state_q == ST_RUNNING);
    assign alarm_active_out = (state_q == ST_ALARM);
    assign mode_down_out    = mode_q;
    assign state_out        = state_q;

endmodule

// File: tb/tb_stopwatch_mode_controller.sv
module tb_stopwatch_mode_controller;

    localparam int CW   = 16;
    localparam int MAXC = 10;
`ifdef LAP_CAPTURE_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic tick, ka, kb, kc, kd, md;
    logic [CW-1:0] pre;

    logic [CW-1:0] cnt_a, lap_a, cnt_b, lap_b;
    logic hold_a, run_a, alm_a, mdo_a, hold_b, run_b, alm_b, mdo_b;
    logic [1:0] st_a, st_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stopwatch_mode_controller #(.CNT_W(CW), .MAX_COUNT(MAXC), .ALARM_TICKS(3)) dut (
        .clk(clk), .reset(reset), .tick_pulse(tick), .key_a_pulse(ka), .key_b_pulse(kb),
        .key_c_pulse(kc), .key_d_pulse(kd), .mode_down(md), .preset_in(pre),
        .count_out(cnt_a), .lap_out(lap_a), .lap_hold_out(hold_a), .run_en_out(run_a),
        .alarm_active_out(alm_a), .mode_down_out(mdo_a), .state_out(st_a));

    stopwatch_mode_controller #(.CNT_W(CW), .MAX_COUNT(MAXC), .ALARM_TICKS(0)) dut0 (
        .clk(clk), .reset(reset), .tick_pulse(tick), .key_a_pulse(ka), .key_b_pulse(kb),
        .key_c_pulse(kc), .key_d_pulse(kd), .mode_down(md), .preset_in(pre),
        .count_out(cnt_b), .lap_out(lap_b), .lap_hold_out(hold_b), .run_en_out(run_b),
        .alarm_active_out(alm_b), .mode_down_out(mdo_b), .state_out(st_b));

    typedef struct { bit a; bit b; bit c; bit d; bit tk; bit md; int pre; } in_t;
    // Model state: 0 idle, 1 running, 2 paused, 3 alarm (the published encodings).
    typedef struct { int st; int cnt; int lap; bit hold; bit md; int tmr; } mdl_t;
    typedef struct { in_t i; int st; int cnt; int lap; bit hold; } vec_t;

    mdl_t m3, m0;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic in_t mk(bit a, bit b, bit c, bit d, bit tk, bit mdv, int p);
        in_t r;
        r.a = a; r.b = b; r.c = c; r.d = d; r.tk = tk; r.md = mdv; r.pre = p;
        return r;
    endfunction

    function automatic mdl_t mreset();
        mdl_t r;
        r.st = 0; r.cnt = 0; r.lap = 0; r.hold = 0; r.md = 0; r.tmr = 0;
        return r;
    endfunction

    // Reference behaviour: one clock edge worth of the stopwatch rules.
    function automatic mdl_t mstep(mdl_t m, in_t i, int at);
        mdl_t n = m;
        bit   to_idle = 0;
        case (m.st)
            0: begin
                n.md = i.md;
                if (i.a && (!i.md || i.pre != 0)) begin
                    n.st  = 1;
                    n.cnt = i.md ? i.pre : 0;
                end
            end
            1: begin
                if (i.c) to_idle = 1;
                else begin
                    if (LAP_EN && i.d && !i.b) begin
                        if (m.hold) n.hold = 0;
                        else begin n.lap = m.cnt; n.hold = 1; end
                    end
                    if (i.tk) n.cnt = m.md ? m.cnt - 1 : m.cnt + 1;
                    if (i.tk && n.cnt == (m.md ? 0 : MAXC)) begin n.st = 3; n.tmr = 0; end
                    else if (i.b) n.st = 2;
                end
            end
            2: begin
                if (i.c) to_idle = 1;
                else if (i.a) n.st = 1;
                else if (LAP_EN && i.d && m.hold) n.hold = 0;
            end
            default: begin
                if (i.tk) n.tmr = m.tmr + 1;
                if (i.c || (at > 0 && n.tmr == at)) to_idle = 1;
                else if (LAP_EN && i.d && m.hold) n.hold = 0;
            end
        endcase
        if (to_idle) begin
            n.st = 0; n.cnt = 0; n.lap = 0; n.hold = 0; n.tmr = 0;
        end
        return n;
    endfunction

    function automatic void push(in_t i, int st, int cnt, int lap, bit hold);
        vec_t v;
        v.i = i; v.st = st; v.cnt = cnt; v.lap = lap; v.hold = hold;
        tbl.push_back(v);
    endfunction

    task automatic drive(input in_t i);
        ka = i.a; kb = i.b; kc = i.c; kd = i.d; tick = i.tk; md = i.md; pre = CW'(i.pre);
    endtask

    task automatic check_models();
        chk("a_state", st_a, m3.st);
        chk("a_count", cnt_a, m3.cnt);
        chk("a_lap", lap_a, m3.lap);
        chk("a_hold", hold_a, m3.hold);
        chk("a_run", run_a, m3.st == 1);
        chk("a_alarm", alm_a, m3.st == 3);
        chk("a_mode", mdo_a, m3.md);
        chk("b_state", st_b, m0.st);
        chk("b_count", cnt_b, m0.cnt);
        chk("b_lap", lap_b, m0.lap);
        chk("b_hold", hold_b, m0.hold);
        chk("b_mode", mdo_b, m0.md);
    endtask

    // Apply one cycle of inputs, then sample after the edge and compare with both models.
    task automatic cycle(input in_t i);
        drive(i);
        @(posedge clk);
        #1;
        m3 = mstep(m3, i, 3);
        m0 = mstep(m0, i, 0);
        check_models();
    endtask

    task automatic chk_all_reset();
        chk("rst_count", cnt_a, 0);
        chk("rst_lap", lap_a, 0);
        chk("rst_hold", hold_a, 0);
        chk("rst_run", run_a, 0);
        chk("rst_alarm", alm_a, 0);
        chk("rst_mode", mdo_a, 0);
        chk("rst_state", st_a, 0);
        chk("rst_state0", st_b, 0);
        chk("rst_count0", cnt_b, 0);
    endtask

    in_t idle_i, tk_i, a_up, c_i;

    initial begin
        idle_i = mk(0, 0, 0, 0, 0, 0, 0);
        tk_i   = mk(0, 0, 0, 0, 1, 0, 0);
        a_up   = mk(1, 0, 0, 0, 0, 0, 0);
        c_i    = mk(0, 0, 1, 0, 0, 0, 0);

        reset = 1'b1;
        drive(idle_i);
        m3 = mreset();
        m0 = mreset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_reset();
        reset = 1'b0;

        // Up mode to terminal, alarm timeout after 3 ticks.
        push(a_up, 1, 0, 0, 0);
        for (int k = 1; k <= MAXC; k++) push(tk_i, (k == MAXC) ? 3 : 1, k, 0, 0);
        push(tk_i, 3, MAXC, 0, 0);
        push(tk_i, 3, MAXC, 0, 0);
        push(tk_i, 0, 0, 0, 0);
        push(c_i, 0, 0, 0, 0);
        // Down mode from preset 5, then preset 0 ignored.
        push(mk(1, 0, 0, 0, 0, 1, 5), 1, 5, 0, 0);
        for (int k = 4; k >= 0; k--) push(mk(0, 0, 0, 0, 1, 1, 5), (k == 0) ? 3 : 1, k, 0, 0);
        push(c_i, 0, 0, 0, 0);
        push(mk(1, 0, 0, 0, 0, 1, 0), 0, 0, 0, 0);
        // Pause together with a tick, resume, clear together with a tick.
        push(a_up, 1, 0, 0, 0);
        for (int k = 1; k <= 4; k++) push(tk_i, 1, k, 0, 0);
        push(mk(0, 1, 0, 0, 1, 0, 0), 2, 5, 0, 0);
        for (int k = 0; k < 3; k++) push(tk_i, 2, 5, 0, 0);
        push(a_up, 1, 5, 0, 0);
        push(mk(0, 0, 1, 0, 1, 0, 0), 0, 0, 0, 0);
        // Lap capture, hold across ticks, release; capture with a tick takes the pre-tick value.
        push(a_up, 1, 0, 0, 0);
        for (int k = 1; k <= 7; k++) push(tk_i, 1, k, 0, 0);
        push(mk(0, 0, 0, 1, 0, 0, 0), 1, 7, 7, 1);
        push(tk_i, 1, 8, 7, 1);
        push(tk_i, 1, 9, 7, 1);
        push(mk(0, 0, 0, 1, 0, 0, 0), 1, 9, 7, 0);
        push(c_i, 0, 0, 0, 0);
        push(a_up, 1, 0, 0, 0);
        push(tk_i, 1, 1, 0, 0);
        push(tk_i, 1, 2, 0, 0);
        push(mk(0, 0, 0, 1, 1, 0, 0), 1, 3, 2, 1);
        push(c_i, 0, 0, 0, 0);

        for (int k = 0; k < tbl.size(); k++) begin
            cycle(tbl[k].i);
            chk("tbl_state", st_a, tbl[k].st);
            chk("tbl_count", cnt_a, tbl[k].cnt);
            chk("tbl_lap", lap_a, LAP_EN ? tbl[k].lap : 0);
            chk("tbl_hold", hold_a, LAP_EN ? tbl[k].hold : 1'b0);
        end

        // Asynchronous reset while running at count 3.
        cycle(a_up);
        repeat (3) cycle(tk_i);
        chk("pre_rst_count", cnt_a, 3);
        #2;
        reset = 1'b1;
        #1;
        chk_all_reset();
        m3 = mreset();
        m0 = mreset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(idle_i);

        // mode_down toggled while paused is not latched.
        cycle(a_up);
        cycle(tk_i);
        cycle(mk(0, 1, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) cycle(mk(0, 0, 0, 0, 0, ~k[0], 0));
        chk("paused_mode", mdo_a, 0);
        cycle(mk(1, 0, 0, 0, 0, 1, 0));
        cycle(mk(0, 0, 0, 0, 1, 1, 0));
        chk("resumed_up_count", cnt_a, 2);
        cycle(c_i);

        // No-timeout alarm on dut0 lasts until C.
        cycle(a_up);
        repeat (MAXC) cycle(tk_i);
        repeat (100) cycle(tk_i);
        chk("alarm0_state", st_b, 3);
        chk("alarm0_count", cnt_b, MAXC);
        chk("alarm3_state", st_a, 0);
        cycle(c_i);
        chk("alarm0_cleared", st_b, 0);

        // Randomised traffic against the models.
        for (int n = 0; n < 3000; n++) begin
            in_t r;
            r.a   = ($urandom_range(0, 5) == 0);
            r.b   = ($urandom_range(0, 9) == 0);
            r.c   = ($urandom_range(0, 24) == 0);
            r.d   = ($urandom_range(0, 7) == 0);
            r.tk  = ($urandom_range(0, 1) == 1);
            r.md  = ($urandom_range(0, 1) == 1);
            r.pre = $urandom_range(0, 8);
            cycle(r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
